// File: rtl/store_unit.sv
// store_unit: narrows MEM-stage store operands into byte-lane form, buffers
// them in a small FIFO and drains them to data memory in program order.
// Misaligned or reserved requests are dropped and raise a one-cycle AdES pulse.
//
// Handshakes: req side transfers on a rising edge with req_valid & req_ready;
// memory side transfers with mem_valid & mem_ready. A valid holder keeps its
// payload stable until the transfer happens, and ready never depends
// combinationally on the partner's valid.
module store_unit #(
    parameter int DEPTH = 2,
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    input  logic [1:0]       req_op,
    input  logic [31:0]      req_addr,
    input  logic [31:0]      req_data,
    output logic             req_ready,
    output logic             exc_ades,
    output logic [31:0]      exc_addr,
    output logic             mem_valid,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    output logic [3:0]       mem_byteen,
    input  logic             mem_ready,
    output logic             buf_empty,
    output logic [CNT_W-1:0] pend_cnt
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Store buffer storage: word address, lane-replicated data, byte enables.
    logic [29:0]      r_addr_mem [DEPTH];
    logic [31:0]      r_data_mem [DEPTH];
    logic [3:0]       r_be_mem   [DEPTH];

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_exc_ades;
    logic [31:0]      r_exc_addr;

    logic             w_legal;
    logic [3:0]       w_be;
    logic [31:0]      w_wdata;
    logic             w_accept;
    logic             w_push;
    logic             w_pop;
    logic             w_not_empty;

    // Full/empty come from the registered count only, so a pop cannot reopen
    // req_ready in the same cycle and no req_* input reaches the mem_* outputs.
    assign w_not_empty = (r_count != '0);
    assign req_ready   = (r_count != CNT_W'(DEPTH));
    assign w_accept    = req_valid & req_ready;
    assign w_push      = w_accept & w_legal;
    assign w_pop       = w_not_empty & mem_ready;

    // Legality check and byte-lane translation of the incoming request.
    always_comb begin
        w_legal = 1'b0;
        w_be    = 4'b0000;
        w_wdata = 32'h0;
        case (req_op)
            2'b00: begin
                w_legal = (req_addr[1:0] == 2'b00);
                w_be    = 4'b1111;
                w_wdata = req_data;
            end
            2'b01: begin
                w_legal = ~req_addr[0];
                w_be    = req_addr[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{req_data[15:0]}};
            end
            2'b10: begin
                w_legal = 1'b1;
                w_be    = 4'b0001 << req_addr[1:0];
                w_wdata = {4{req_data[7:0]}};
            end
            default: begin
                w_legal = 1'b0;
            end
        endcase
    end

    // Buffer entries are written at the tail on a legal accept; reset clears
    // them so the memory-side outputs read as zero after reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_addr_mem[i] <= '0;
                r_data_mem[i] <= '0;
                r_be_mem[i]   <= '0;
            end
        end else if (w_push) begin
            r_addr_mem[r_wr_ptr] <= req_addr[31:2];
            r_data_mem[r_wr_ptr] <= w_wdata;
            r_be_mem[r_wr_ptr]   <= w_be;
        end
    end

    // Pointers (wrap modulo DEPTH via natural overflow) and occupancy count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Exception pulse for a rejected accept; the address is held until the
    // next rejection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_exc_ades <= 1'b0;
            r_exc_addr <= 32'h0;
        end else begin
            r_exc_ades <= w_accept & ~w_legal;
            if (w_accept & ~w_legal) begin
                r_exc_addr <= req_addr;
            end
        end
    end

    assign exc_ades   = r_exc_ades;
    assign exc_addr   = r_exc_addr;
    assign mem_valid  = w_not_empty;
    assign mem_addr   = {r_addr_mem[r_rd_ptr], 2'b00};
    assign mem_wdata  = r_data_mem[r_rd_ptr];
    assign mem_byteen = r_be_mem[r_rd_ptr];
    assign buf_empty  = ~w_not_empty;
    assign pend_cnt   = r_count;

endmodule

// File: doc/store_unit.md
Name: store_unit

Overview:
- Write-side counterpart of the load/immediate extension path. It narrows 32-bit store operands from the MEM stage into byte-lane form for data memory: byte enables, lane-replicated write data and a word-aligned address.
- Buffers up to DEPTH stores in a FIFO and drains them to memory over a valid/ready handshake.
- Rejects misaligned or reserved requests and raises a store address exception (AdES).

Parameters:
- DEPTH, 2, store buffer entries; power of two, at least 2.
- CNT_W, 2, width of pend_cnt; must satisfy 2^CNT_W > DEPTH.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- req_valid  input  1  MEM stage presents a store.
- req_op  input  2  store type: 00 sw, 01 sh, 10 sb, 11 reserved.
- req_addr  input  32  byte address.
- req_data  input  32  rt register value; the low 8 or 16 bits are used for sb and sh.
- req_ready  output  1  buffer can accept; equals (count != DEPTH).
- exc_ades  output  1  registered one-cycle pulse: the last accepted request was rejected.
- exc_addr  output  32  offending byte address; held until the next rejection.
- mem_valid  output  1  head entry presented to memory.
- mem_addr  output  32  {head_addr[31:2], 2'b00}.
- mem_wdata  output  32  lane-replicated write data.
- mem_byteen  output  4  byte enables, little-endian (bit i = byte i).
- mem_ready  input  1  memory accepts the head this cycle.
- buf_empty  output  1  no pending stores; the CPU stalls loads and syscall on !buf_empty.
- pend_cnt  output  CNT_W  number of pending entries.

Behaviour:
- Reset values: count 0, wr_ptr 0, rd_ptr 0, req_ready 1, exc_ades 0, exc_addr 0, mem_valid 0, mem_addr 0, mem_wdata 0, mem_byteen 0, buf_empty 1, pend_cnt 0.
- Reset asserted mid-drain: all entries are discarded and mem_valid drops immediately; no partial write completes.
- Accept: a request is accepted on a rising edge with req_valid & req_ready.
- Legality check, applied at accept:
  - sw legal iff addr[1:0] == 0.
  - sh legal iff addr[0] == 0.
  - sb is always legal.
  - op 11 is always illegal.
- Illegal request: not enqueued. On the next cycle exc_ades = 1 for exactly one cycle and exc_addr = req_addr. Buffer state is unchanged.
- Translation, computed at enqueue and stored per entry:
  - sw: byteen 1111, wdata = data.
  - sh: byteen = addr[1] ? 1100 : 0011; wdata = {2{data[15:0]}}.
  - sb: byteen = 0001 << addr[1:0]; wdata = {4{data[7:0]}}.
- FIFO: entries hold {word_addr[31:2], wdata, byteen}. Pointers wrap modulo DEPTH.
- Memory side:
  - mem_valid = (count != 0). mem_addr, mem_wdata and mem_byteen come from the head entry.
  - While mem_valid & !mem_ready, all memory-side outputs hold stable.
  - Pop on mem_valid & mem_ready.
  - Outputs are driven from registers/array with no combinational path from req_* to mem_*.
- Latency: a store accepted at edge N into an empty buffer asserts mem_valid in the cycle after edge N. Minimum one cycle; there is no bypass.
- Simultaneous push and pop (0 < count < DEPTH): count unchanged, both pointers advance, ordering preserved.
- Full: req_ready = 0, and a pop in the same cycle does not reopen it combinationally. req_ready rises in the cycle after the pop.
- Empty: mem_ready is ignored and no pop occurs.
- Illegal request while full: not accepted (req_ready = 0), so no exception fires until it is accepted.
- Stores drain strictly in program order. pend_cnt = count; buf_empty = (count == 0).

Test Plan:
- sb sequence: addr 0x1001, 0x1002, 0x1003 with data 0x000000AB, mem_ready=1 -> mem_addr 0x1000 each time; byteen 0010, 0100, 1000; wdata 0xABABABAB; mem_valid first high one cycle after accept.
- sh to 0x2002 with data 0x1234CAFE -> byteen 1100, wdata 0xCAFECAFE, mem_addr 0x2000. sw 0x3000 with 0xDEADBEEF -> byteen 1111.
- Misaligned sw to 0x4002, sh to 0x4001, op=11 -> exc_ades pulses exactly one cycle each, exc_addr = offending address, pend_cnt stays 0, mem_valid never asserts.
- Backpressure: mem_ready=0 with 3 sw issued -> 2 accepted, req_ready=0 on the third, mem_* outputs stable. Then mem_ready=1 for one cycle -> first store pops, req_ready returns the next cycle, third store accepted, order preserved.
- Push/pop same cycle with count=1 -> pend_cnt remains 1, data ordering correct. Pointer wrap verified over 10 consecutive stores.
- Reset asserted asynchronously mid-cycle with 2 pending and mem_ready=0 -> mem_valid, pend_cnt and exc_ades go to 0 immediately without waiting for a clock edge; buf_empty=1, and the first post-reset store occupies entry 0.
